// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side sequencer for the UART.
// Synchronises the RX line, finds the start bit, strobes the external shift
// register at each data-bit centre and reports frame completion or error.
// Optional feature: define PARITY_CHECK_EN to receive and check one even
// parity bit after the data bits (parity_err is tied low otherwise).
module uart_rx_ctrl #(
    parameter int unsigned WORD_LENGTH = 8,
    parameter int unsigned CLK_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic SerialDataIn,
    output logic rx_bit,
    output logic shift,
    output logic busy,
    output logic rx_done,
    output logic frame_err,
    output logic parity_err
);

    localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
    localparam int unsigned BIT_W = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
    localparam int unsigned HALF  = CLK_PER_BIT / 2 - 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
`ifdef PARITY_CHECK_EN
    localparam logic [2:0] PARITY = 3'd4;
`endif

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             shift_q, shift_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ferr_q, ferr_d;
    logic             tick_c;
`ifdef PARITY_CHECK_EN
    logic             par_q, par_d;
    logic             pend_q, pend_d;
    logic             perr_q, perr_d;
`endif

    // Next-state, counter and strobe logic
    always_comb begin
        sync1_d = SerialDataIn;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = 1'b0;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
`ifdef PARITY_CHECK_EN
        par_d   = par_q;
        pend_d  = pend_q;
        perr_d  = 1'b0;
`endif
        tick_c  = (baud_q == CNT_W'(CLK_PER_BIT - 1));

        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                // Only a fresh 1->0 edge starts a frame; a held-low line does not
                if (prev_q && !sync2_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (baud_q == CNT_W'(HALF)) begin
                    baud_d = '0;
                    bit_d  = '0;
                    if (!sync2_q) begin
                        state_d = DATA;
`ifdef PARITY_CHECK_EN
                        par_d  = 1'b0;
                        pend_d = 1'b0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            DATA: begin
                baud_d = tick_c ? '0 : baud_q + CNT_W'(1);
                if (tick_c) begin
                    shift_d = 1'b1;
`ifdef PARITY_CHECK_EN
                    par_d = par_q ^ sync2_q;
`endif
                    if (bit_q == BIT_W'(WORD_LENGTH - 1)) begin
                        bit_d = '0;
`ifdef PARITY_CHECK_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
`ifdef PARITY_CHECK_EN
            PARITY: begin
                baud_d = tick_c ? '0 : baud_q + CNT_W'(1);
                if (tick_c) begin
                    // Even parity: data XOR parity bit must be zero
                    pend_d  = par_q ^ sync2_q;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                baud_d = tick_c ? '0 : baud_q + CNT_W'(1);
                if (tick_c) begin
                    state_d = IDLE;
                    done_d  = sync2_q;
                    ferr_d  = !sync2_q;
`ifdef PARITY_CHECK_EN
                    perr_d  = pend_q;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_q   <= 1'b0;
            pend_q  <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
`ifdef PARITY_CHECK_EN
            par_q   <= par_d;
            pend_q  <= pend_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign rx_bit    = sync2_q;
    assign shift     = shift_q;
    assign busy      = busy_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;
`ifdef PARITY_CHECK_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
